// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: EX/LS/WB producer info in, final EX operands and register controls out.
// The master side drives the pipeline view; the slave side is the controller.
interface hazard_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic [4:0]      rs1_idx_id, rs2_idx_id;
  logic [4:0]      rs1_idx_ex, rs2_idx_ex;
  logic [XLEN-1:0] rs1_ex, rs2_ex;
  logic [4:0]      rd_idx_ex;
  logic            wben_ex, is_load_ex, is_jump_ex;
  logic [4:0]      rd_idx_ls;
  logic            wben_ls, is_load_ls;
  logic [XLEN-1:0] alures_ls;
  logic [4:0]      rd_idx_wb;
  logic            wben_wb;
  logic [XLEN-1:0] wb_data;
  logic            mem_busy;
  logic [XLEN-1:0] rs1_fwd_o, rs2_fwd_o;
  logic            stall_pc_o, stall_id_o, stall_ex_o, stall_ls_o;
  logic            bubble_ex_o, bubble_wb_o;
  logic            flush_id_o, flush_ex_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  modport master (
    output rs1_idx_id, rs2_idx_id, rs1_idx_ex, rs2_idx_ex, rs1_ex, rs2_ex,
           rd_idx_ex, wben_ex, is_load_ex, is_jump_ex,
           rd_idx_ls, wben_ls, is_load_ls, alures_ls,
           rd_idx_wb, wben_wb, wb_data, mem_busy,
    input  rs1_fwd_o, rs2_fwd_o, stall_pc_o, stall_id_o, stall_ex_o, stall_ls_o,
           bubble_ex_o, bubble_wb_o, flush_id_o, flush_ex_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  rs1_idx_id, rs2_idx_id, rs1_idx_ex, rs2_idx_ex, rs1_ex, rs2_ex,
           rd_idx_ex, wben_ex, is_load_ex, is_jump_ex,
           rd_idx_ls, wben_ls, is_load_ls, alures_ls,
           rd_idx_wb, wben_wb, wb_data, mem_busy,
    output rs1_fwd_o, rs2_fwd_o, stall_pc_o, stall_id_o, stall_ex_o, stall_ls_o,
           bubble_ex_o, bubble_wb_o, flush_id_o, flush_ex_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller beside EX: operands and stall/bubble/flush are combinational, FSM/history/counters
// update on clk; it applies backpressure only through the stall outputs. Counters exist only with HAZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int XLEN       = 64,
  parameter int HIST_DEPTH = 1,
  parameter int CNT_W      = 32
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, LU, MEM} state_t;

  state_t          state, state_nxt;
  logic            pending, pending_nxt;
  logic            load_use, flush_req, lu_stall;
  logic            ls_ok, wb_ok;
  logic            h1_hit, h2_hit;
  logic [XLEN-1:0] h1_dat, h2_dat;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  assign load_use = bus.is_load_ex && bus.wben_ex && (bus.rd_idx_ex != 5'd0) &&
                    ((bus.rd_idx_ex == bus.rs1_idx_id) || (bus.rd_idx_ex == bus.rs2_idx_id));
  // A jump seen while memory was busy is replayed on the first free cycle.
  assign flush_req = !bus.mem_busy && (bus.is_jump_ex || pending);
  assign lu_stall  = load_use && !bus.mem_busy && !flush_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    if (bus.mem_busy && bus.is_jump_ex) pending_nxt = 1'b1;
    else if (flush_req)                 pending_nxt = 1'b0;
    case (state)
      RUN: begin
        if (bus.mem_busy)  state_nxt = MEM;
        else if (lu_stall) state_nxt = LU;
      end
      LU:      state_nxt = bus.mem_busy ? MEM : RUN;
      MEM:     if (!bus.mem_busy) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Controls are gated by rst_n so they fall the instant reset asserts.
  always_comb begin
    bus.stall_pc_o  = 1'b0;
    bus.stall_id_o  = 1'b0;
    bus.stall_ex_o  = 1'b0;
    bus.stall_ls_o  = 1'b0;
    bus.bubble_ex_o = 1'b0;
    bus.bubble_wb_o = 1'b0;
    bus.flush_id_o  = 1'b0;
    bus.flush_ex_o  = 1'b0;
    if (rst_n) begin
      if (bus.mem_busy) begin
        bus.stall_pc_o  = 1'b1;
        bus.stall_id_o  = 1'b1;
        bus.stall_ex_o  = 1'b1;
        bus.stall_ls_o  = 1'b1;
        bus.bubble_wb_o = 1'b1;
      end else if (flush_req) begin
        bus.flush_id_o  = 1'b1;
        bus.flush_ex_o  = 1'b1;
      end else if (lu_stall) begin
        bus.stall_pc_o  = 1'b1;
        bus.stall_id_o  = 1'b1;
        bus.bubble_ex_o = 1'b1;
      end
    end
  end

  generate
    if (HIST_DEPTH > 0) begin : g_hist
      logic [HIST_DEPTH-1:0] h_vld;
      logic [4:0]            h_rd  [HIST_DEPTH];
      logic [XLEN-1:0]       h_dat [HIST_DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          h_vld <= '0;
          for (int i = 0; i < HIST_DEPTH; i++) begin
            h_rd[i]  <= '0;
            h_dat[i] <= '0;
          end
        end else if (!bus.stall_ex_o) begin
          h_vld[0] <= bus.wben_wb && (bus.rd_idx_wb != 5'd0);
          h_rd[0]  <= bus.rd_idx_wb;
          h_dat[0] <= bus.wb_data;
          for (int i = 1; i < HIST_DEPTH; i++) begin
            h_vld[i] <= h_vld[i-1];
            h_rd[i]  <= h_rd[i-1];
            h_dat[i] <= h_dat[i-1];
          end
        end
      end

      // Walk oldest to newest so the newest matching entry wins.
      always_comb begin
        h1_hit = 1'b0;
        h2_hit = 1'b0;
        h1_dat = '0;
        h2_dat = '0;
        for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
          if (h_vld[i] && (h_rd[i] == bus.rs1_idx_ex)) begin
            h1_hit = 1'b1;
            h1_dat = h_dat[i];
          end
          if (h_vld[i] && (h_rd[i] == bus.rs2_idx_ex)) begin
            h2_hit = 1'b1;
            h2_dat = h_dat[i];
          end
        end
      end
    end else begin : g_no_hist
      assign h1_hit = 1'b0;
      assign h2_hit = 1'b0;
      assign h1_dat = '0;
      assign h2_dat = '0;
    end
  endgenerate

  assign ls_ok = bus.wben_ls && !bus.is_load_ls;
  assign wb_ok = bus.wben_wb;

  // Later assignments override earlier ones: lowest priority first.
  always_comb begin
    rs1_fwd = bus.rs1_ex;
    if (h1_hit) rs1_fwd = h1_dat;
    if (wb_ok && (bus.rd_idx_wb == bus.rs1_idx_ex)) rs1_fwd = bus.wb_data;
    if (ls_ok && (bus.rd_idx_ls == bus.rs1_idx_ex)) rs1_fwd = bus.alures_ls;
    if (bus.rs1_idx_ex == 5'd0) rs1_fwd = bus.rs1_ex;

    rs2_fwd = bus.rs2_ex;
    if (h2_hit) rs2_fwd = h2_dat;
    if (wb_ok && (bus.rd_idx_wb == bus.rs2_idx_ex)) rs2_fwd = bus.wb_data;
    if (ls_ok && (bus.rd_idx_ls == bus.rs2_idx_ex)) rs2_fwd = bus.alures_ls;
    if (bus.rs2_idx_ex == 5'd0) rs2_fwd = bus.rs2_ex;
  end

  assign bus.rs1_fwd_o = rs1_fwd;
  assign bus.rs2_fwd_o = rs2_fwd;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.stall_pc_o && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      if (bus.flush_ex_o && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;
`else
  assign bus.stall_cnt_o = {CNT_W{1'b0}};
  assign bus.flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes expected values into a queue, a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int S_RS1 = 0, S_RS2 = 1, S_CTRL = 2, S_SCNT = 3, S_FCNT = 4, S_RS1_H0 = 5, S_RS2_H0 = 6;
  localparam logic [7:0] C_IDLE = 8'h00, C_LU = 8'hC8, C_MEM = 8'hF4, C_FLUSH = 8'h03;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  hazard_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus0 ();

  hazard_ctrl #(.XLEN(XLEN), .HIST_DEPTH(1), .CNT_W(CNT_W)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  hazard_ctrl #(.XLEN(XLEN), .HIST_DEPTH(0), .CNT_W(CNT_W)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  assign bus0.rs1_idx_id = bus.rs1_idx_id;
  assign bus0.rs2_idx_id = bus.rs2_idx_id;
  assign bus0.rs1_idx_ex = bus.rs1_idx_ex;
  assign bus0.rs2_idx_ex = bus.rs2_idx_ex;
  assign bus0.rs1_ex     = bus.rs1_ex;
  assign bus0.rs2_ex     = bus.rs2_ex;
  assign bus0.rd_idx_ex  = bus.rd_idx_ex;
  assign bus0.wben_ex    = bus.wben_ex;
  assign bus0.is_load_ex = bus.is_load_ex;
  assign bus0.is_jump_ex = bus.is_jump_ex;
  assign bus0.rd_idx_ls  = bus.rd_idx_ls;
  assign bus0.wben_ls    = bus.wben_ls;
  assign bus0.is_load_ls = bus.is_load_ls;
  assign bus0.alures_ls  = bus.alures_ls;
  assign bus0.rd_idx_wb  = bus.rd_idx_wb;
  assign bus0.wben_wb    = bus.wben_wb;
  assign bus0.wb_data    = bus.wb_data;
  assign bus0.mem_busy   = bus.mem_busy;

  exp_t q[$];
  exp_t e;
  logic [63:0] act;
  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.sel)
        S_RS1:    act = bus.rs1_fwd_o;
        S_RS2:    act = bus.rs2_fwd_o;
        S_CTRL:   act = 64'({bus.stall_pc_o, bus.stall_id_o, bus.stall_ex_o, bus.stall_ls_o,
                             bus.bubble_ex_o, bus.bubble_wb_o, bus.flush_id_o, bus.flush_ex_o});
        S_SCNT:   act = 64'(bus.stall_cnt_o);
        S_FCNT:   act = 64'(bus.flush_cnt_o);
        S_RS1_H0: act = bus0.rs1_fwd_o;
        S_RS2_H0: act = bus0.rs2_fwd_o;
        default:  act = 'x;
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic push(input string name, input int sel, input logic [63:0] val);
    exp_t x;
    x.name = name;
    x.sel  = sel;
    x.exp  = val;
    q.push_back(x);
  endtask

  task automatic clr();
    bus.rs1_idx_id = '0; bus.rs2_idx_id = '0;
    bus.rs1_idx_ex = '0; bus.rs2_idx_ex = '0;
    bus.rs1_ex = '0;     bus.rs2_ex = '0;
    bus.rd_idx_ex = '0;  bus.wben_ex = 1'b0; bus.is_load_ex = 1'b0; bus.is_jump_ex = 1'b0;
    bus.rd_idx_ls = '0;  bus.wben_ls = 1'b0; bus.is_load_ls = 1'b0; bus.alures_ls = '0;
    bus.rd_idx_wb = '0;  bus.wben_wb = 1'b0; bus.wb_data = '0;
    bus.mem_busy = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    clr();
    push("reset_ctrl", S_CTRL, 64'(C_IDLE));
    push("reset_scnt", S_SCNT, 64'd0);
    push("reset_fcnt", S_FCNT, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LS forwards ALU result to both operands
    step();
    bus.rs1_idx_ex = 5'd5; bus.rs2_idx_ex = 5'd5; bus.rs1_ex = 64'hAA; bus.rs2_ex = 64'hAA;
    bus.rd_idx_ls = 5'd5; bus.wben_ls = 1'b1; bus.alures_ls = 64'h10;
    push("ls_fwd_rs1", S_RS1, 64'h10);
    push("ls_fwd_rs2", S_RS2, 64'h10);
    push("ls_fwd_ctrl", S_CTRL, 64'(C_IDLE));

    // LS beats WB; load in LS defers to WB
    step();
    bus.rs1_idx_ex = 5'd3; bus.rs1_ex = 64'h77;
    bus.rd_idx_ls = 5'd3; bus.wben_ls = 1'b1; bus.alures_ls = 64'h1;
    bus.rd_idx_wb = 5'd3; bus.wben_wb = 1'b1; bus.wb_data = 64'h2;
    push("ls_over_wb", S_RS1, 64'h1);
    step();
    bus.rs1_idx_ex = 5'd3; bus.rs1_ex = 64'h77;
    bus.rd_idx_ls = 5'd3; bus.wben_ls = 1'b1; bus.is_load_ls = 1'b1; bus.alures_ls = 64'h1;
    bus.rd_idx_wb = 5'd3; bus.wben_wb = 1'b1; bus.wb_data = 64'h2;
    push("load_ls_uses_wb", S_RS1, 64'h2);

    // x0 never forwarded; rs2 x3 comes from history only with depth 1
    step();
    bus.rs1_idx_ex = 5'd0; bus.rs1_ex = 64'h77; bus.rs2_idx_ex = 5'd3; bus.rs2_ex = 64'h99;
    bus.rd_idx_ls = 5'd0; bus.wben_ls = 1'b1; bus.alures_ls = 64'h1;
    bus.rd_idx_wb = 5'd0; bus.wben_wb = 1'b1; bus.wb_data = 64'h2;
    push("x0_passthru", S_RS1, 64'h77);
    push("hist_rs2", S_RS2, 64'h2);
    push("hist0_rs2", S_RS2_H0, 64'h99);

    step();
    bus.rd_idx_wb = 5'd9; bus.wben_wb = 1'b1; bus.wb_data = 64'h55;
    step();
    bus.rs1_idx_ex = 5'd9; bus.rs1_ex = 64'h0;
    push("hist_rs1", S_RS1, 64'h55);
    push("hist0_rs1", S_RS1_H0, 64'h0);

    // Load-use: one stall cycle, then WB forwards
    step();
    bus.is_load_ex = 1'b1; bus.wben_ex = 1'b1; bus.rd_idx_ex = 5'd7; bus.rs1_idx_id = 5'd7;
    push("lu_ctrl", S_CTRL, 64'(C_LU));
    step();
    bus.rs1_idx_ex = 5'd7; bus.rs1_ex = 64'h3;
    bus.rd_idx_ls = 5'd7; bus.wben_ls = 1'b1; bus.is_load_ls = 1'b1; bus.alures_ls = 64'hBEEF;
    push("lu_after_ctrl", S_CTRL, 64'(C_IDLE));
    push("lu_no_ls_fwd", S_RS1, 64'h3);
    push("lu_scnt", S_SCNT, PERF ? 64'd1 : 64'd0);
    step();
    bus.rs1_idx_ex = 5'd7; bus.rs1_ex = 64'h0;
    bus.rd_idx_wb = 5'd7; bus.wben_wb = 1'b1; bus.wb_data = 64'hDEAD;
    push("lu_wb_fwd", S_RS1, 64'hDEAD);

    // Jump overrides a concurrent load-use hazard
    step();
    bus.is_jump_ex = 1'b1;
    bus.is_load_ex = 1'b1; bus.wben_ex = 1'b1; bus.rd_idx_ex = 5'd8; bus.rs2_idx_id = 5'd8;
    push("jump_over_lu", S_CTRL, 64'(C_FLUSH));
    step();
    bus.rd_idx_wb = 5'd11; bus.wben_wb = 1'b1; bus.wb_data = 64'h11;
    push("post_jump_ctrl", S_CTRL, 64'(C_IDLE));
    push("post_jump_fcnt", S_FCNT, PERF ? 64'd1 : 64'd0);

    // Jump during 3 busy cycles: freeze, then single deferred flush; history holds
    for (int i = 0; i < 3; i++) begin
      step();
      bus.mem_busy = 1'b1; bus.is_jump_ex = 1'b1;
      bus.rd_idx_wb = 5'd12; bus.wben_wb = 1'b1; bus.wb_data = 64'h12;
      push($sformatf("mem_freeze_%0d", i), S_CTRL, 64'(C_MEM));
    end
    step();
    bus.is_jump_ex = 1'b1; bus.rs1_idx_ex = 5'd11; bus.rs1_ex = 64'h0;
    push("mem_exit_flush", S_CTRL, 64'(C_FLUSH));
    push("hist_held", S_RS1, 64'h11);
    step();
    push("flush_once", S_CTRL, 64'(C_IDLE));
    push("mem_scnt", S_SCNT, PERF ? 64'd4 : 64'd0);
    push("mem_fcnt", S_FCNT, PERF ? 64'd2 : 64'd0);

    // Reset pulsed during MEM with a pending jump
    step();
    bus.rd_idx_wb = 5'd20; bus.wben_wb = 1'b1; bus.wb_data = 64'h20;
    step();
    bus.mem_busy = 1'b1; bus.is_jump_ex = 1'b1;
    push("pre_rst_mem", S_CTRL, 64'(C_MEM));
    step();
    bus.mem_busy = 1'b1; bus.is_jump_ex = 1'b1;
    rst_n = 1'b0;
    push("rst_async_ctrl", S_CTRL, 64'(C_IDLE));
    push("rst_async_scnt", S_SCNT, 64'd0);
    push("rst_async_fcnt", S_FCNT, 64'd0);
    step();
    rst_n = 1'b1;
    bus.rs1_idx_ex = 5'd20; bus.rs1_ex = 64'h5;
    push("rst_hist_clear", S_RS1, 64'h5);
    push("rst_no_pending", S_CTRL, 64'(C_IDLE));
    step();
    bus.is_load_ex = 1'b1; bus.wben_ex = 1'b1; bus.rd_idx_ex = 5'd4; bus.rs2_idx_id = 5'd4;
    push("rst_lu_again", S_CTRL, 64'(C_LU));

    step();
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
